// File: rtl/uart_alu_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_alu_interface
// Description : Sequencer between a UART receiver/transmitter pair and a
//               combinational ALU. Collects operand A, operand B and opcode
//               from three received bytes, presents them to the ALU, captures
//               the result one cycle later and requests its transmission.
//               A partial frame is discarded if the next byte does not arrive
//               in time, and a transmitter that never completes is abandoned.
//
// Ports       : i_clock      - system clock, rising edge
//               i_reset      - asynchronous active-high reset
//               i_rx_done    - receiver done flag (rising edge is the event)
//               i_data_rx    - received byte, valid while i_rx_done is high
//               i_tx_done    - transmitter done flag (rising edge is the event)
//               i_resultado  - combinational ALU result
//               o_dato_A     - ALU operand A (registered)
//               o_dato_B     - ALU operand B (registered)
//               o_opcode     - ALU opcode (registered)
//               o_data_tx    - byte handed to the transmitter (registered)
//               o_tx_start   - one-cycle transmit request
//               o_busy       - high whenever a frame is in progress
//               o_timeout    - one-cycle pulse when a frame is aborted
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_interface #(
    parameter int WIDTH_WORD     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [WIDTH_WORD-1:0] i_data_rx,
    input  logic                  i_tx_done,
    input  logic [WIDTH_WORD-1:0] i_resultado,
    output logic [WIDTH_WORD-1:0] o_dato_A,
    output logic [WIDTH_WORD-1:0] o_dato_B,
    output logic [WIDTH_WORD-1:0] o_opcode,
    output logic [WIDTH_WORD-1:0] o_data_tx,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_timeout
);

    // Counter only ever reaches TIMEOUT_CYCLES-1, so this width never wraps.
    localparam int                CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]     c_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]     c_ONE   = CW'(1);

    localparam logic [2:0] c_ST_WAIT_A  = 3'd0;
    localparam logic [2:0] c_ST_WAIT_B  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_OP = 3'd2;
    localparam logic [2:0] c_ST_EXEC    = 3'd3;
    localparam logic [2:0] c_ST_SEND    = 3'd4;
    localparam logic [2:0] c_ST_WAIT_TX = 3'd5;

    logic [2:0]    r_state;
    logic          r_rx_prev;
    logic          r_tx_prev;
    logic [CW-1:0] r_count;

    logic          w_rx_ev;
    logic          w_tx_ev;
    logic          w_expired;

    // Rising-edge detection: a level held high yields a single event.
    assign w_rx_ev   = i_rx_done & ~r_rx_prev;
    assign w_tx_ev   = i_tx_done & ~r_tx_prev;
    assign w_expired = (r_count == c_LAST);

    assign o_busy    = (r_state != c_ST_WAIT_A);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= c_ST_WAIT_A;
            r_rx_prev  <= 1'b0;
            r_tx_prev  <= 1'b0;
            r_count    <= '0;
            o_dato_A   <= '0;
            o_dato_B   <= '0;
            o_opcode   <= '0;
            o_data_tx  <= '0;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            // Edge registers track the inputs every cycle, so bytes that
            // arrive while they cannot be accepted are consumed and lost.
            r_rx_prev  <= i_rx_done;
            r_tx_prev  <= i_tx_done;
            o_tx_start <= 1'b0;
            o_timeout  <= 1'b0;

            case (r_state)
                c_ST_WAIT_A: begin
                    r_count <= '0;
                    if (w_rx_ev) begin
                        o_dato_A <= i_data_rx;
                        r_state  <= c_ST_WAIT_B;
                    end
                end

                // In every waiting state a real event in the expiry cycle
                // takes priority over the abort.
                c_ST_WAIT_B: begin
                    if (w_rx_ev) begin
                        o_dato_B <= i_data_rx;
                        r_state  <= c_ST_WAIT_OP;
                        r_count  <= '0;
                    end else if (w_expired) begin
                        o_timeout <= 1'b1;
                        r_state   <= c_ST_WAIT_A;
                        r_count   <= '0;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

                c_ST_WAIT_OP: begin
                    if (w_rx_ev) begin
                        o_opcode <= i_data_rx;
                        r_state  <= c_ST_EXEC;
                        r_count  <= '0;
                    end else if (w_expired) begin
                        o_timeout <= 1'b1;
                        r_state   <= c_ST_WAIT_A;
                        r_count   <= '0;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

                // Operands became stable at the previous edge, so the ALU
                // result is settled now. The request is registered here so
                // it is high exactly while in SEND.
                c_ST_EXEC: begin
                    o_data_tx  <= i_resultado;
                    o_tx_start <= 1'b1;
                    r_state    <= c_ST_SEND;
                    r_count    <= '0;
                end

                c_ST_SEND: begin
                    r_state <= c_ST_WAIT_TX;
                    r_count <= '0;
                end

                c_ST_WAIT_TX: begin
                    if (w_tx_ev) begin
                        r_state <= c_ST_WAIT_A;
                        r_count <= '0;
                    end else if (w_expired) begin
                        o_timeout <= 1'b1;
                        r_state   <= c_ST_WAIT_A;
                        r_count   <= '0;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end

                default: begin
                    r_state <= c_ST_WAIT_A;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
